// File: rtl/dense_mac_seq_pkg.sv
// Shared constants and the logit saturation helper for the dense output-layer MAC engine.
package dense_mac_seq_pkg;

    localparam int HID_DIM  = 24;
    localparam int DATA_N   = 6;
    localparam int N_LEN    = 16;
    localparam int CHAR_NUM = 200;
    localparam int FRAC     = 8;
    localparam int AWIDTH   = 10;
    localparam int ACC_W    = 2*N_LEN + 8;
    localparam int IDX_W    = 8;
    localparam int LANE_W   = DATA_N*N_LEN;
    localparam int W_WORDS  = HID_DIM / DATA_N;
    localparam int WW       = (W_WORDS > 1) ? $clog2(W_WORDS) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N_LEN+1){1'b0}}, {(N_LEN-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N_LEN+1){1'b1}}, {(N_LEN-1){1'b0}}};

    // Truncating arithmetic shift back to the data format, then clamp to the signed N_LEN range.
    function automatic logic signed [N_LEN-1:0] sat_logit(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC;
        if (sh > SAT_MAX)
            return SAT_MAX[N_LEN-1:0];
        else if (sh < SAT_MIN)
            return SAT_MIN[N_LEN-1:0];
        else
            return sh[N_LEN-1:0];
    endfunction

endpackage

// File: rtl/dense_mac_seq_lane6.sv
// Combinational DATA_N-lane signed multiply with a summing tree into an ACC_W result.
module dense_mac_lane6
    import dense_mac_seq_pkg::*;
(
    input  logic [LANE_W-1:0]        h_word,
    input  logic [LANE_W-1:0]        w_word,
    output logic signed [ACC_W-1:0]  sum
);

    logic signed [2*N_LEN-1:0] prod [DATA_N];

    for (genvar j = 0; j < DATA_N; j++) begin : g_lane
        assign prod[j] = $signed(h_word[j*N_LEN +: N_LEN]) * $signed(w_word[j*N_LEN +: N_LEN]);
    end

    always_comb begin
        sum = '0;
        for (int j = 0; j < DATA_N; j++)
            sum = sum + ACC_W'(prod[j]);
    end

endmodule

// File: rtl/dense_mac_seq.sv
// Dense output-layer engine: latches a hidden vector, walks the weight ROM and streams saturated logits.
// Optional running argmax output enabled by defining DENSE_ARGMAX_EN.
//
// state | meaning
// IDLE  | waiting for a hidden vector, in_ready high
// FETCH | issuing ROM addresses for the current char, accumulating the previous word
// DRAIN | accumulating the last word of the current char
// EMIT  | presenting the logit until out_ready
module dense_mac_seq
    import dense_mac_seq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [HID_DIM*N_LEN-1:0]  h_in,
    output logic [AWIDTH-1:0]         rom_addr,
    input  logic [LANE_W-1:0]         rom_q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_LEN-1:0]          out_data,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_last
`ifdef DENSE_ARGMAX_EN
    ,
    output logic [IDX_W-1:0]          argmax_idx,
    output logic                      argmax_valid
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_EMIT  = 2'd3;

    logic [1:0]                state, state_nxt;
    logic [IDX_W-1:0]          c_cnt;
    logic [WW-1:0]             w_cnt;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   lane_sum;
    logic [HID_DIM*N_LEN-1:0]  h_reg;
    logic [WW-1:0]             h_sel;
    logic [LANE_W-1:0]         h_word;
    logic signed [N_LEN-1:0]   logit;
    logic                      c_last, w_last, hs;

    assign c_last = (c_cnt == IDX_W'(CHAR_NUM-1));
    assign w_last = (w_cnt == WW'(W_WORDS-1));
    assign hs     = (state == ST_EMIT) && out_ready;

    // rom_q lags the address by one cycle, so FETCH consumes word w-1 and DRAIN the final word.
    assign h_sel  = (state == ST_DRAIN) ? w_cnt : w_cnt - WW'(1);
    assign h_word = h_reg[int'(h_sel)*LANE_W +: LANE_W];
    assign logit  = sat_logit(acc);

    dense_mac_lane6 u_lane (
        .h_word (h_word),
        .w_word (rom_q),
        .sum    (lane_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_FETCH;
            ST_FETCH: if (w_last)   state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_EMIT;
            ST_EMIT:  if (out_ready) state_nxt = c_last ? ST_IDLE : ST_FETCH;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_EMIT);
        out_data  = (state == ST_EMIT) ? logit : '0;
        out_idx   = (state == ST_EMIT) ? c_cnt : '0;
        out_last  = (state == ST_EMIT) && c_last;
        rom_addr  = AWIDTH'(c_cnt) * AWIDTH'(W_WORDS) + AWIDTH'(w_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg <= '0;
            acc   <= '0;
            c_cnt <= '0;
            w_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        h_reg <= h_in;
                        acc   <= '0;
                        c_cnt <= '0;
                        w_cnt <= '0;
                    end
                end
                ST_FETCH: begin
                    if (w_cnt != '0)
                        acc <= acc + lane_sum;
                    if (!w_last)
                        w_cnt <= w_cnt + WW'(1);
                end
                ST_DRAIN: acc <= acc + lane_sum;
                ST_EMIT: begin
                    if (out_ready) begin
                        acc   <= '0;
                        w_cnt <= '0;
                        c_cnt <= c_last ? '0 : c_cnt + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DENSE_ARGMAX_EN
    logic signed [N_LEN-1:0] max_val;
    logic [IDX_W-1:0]        max_idx;
    logic                    take;

    // Strict greater-than keeps the earlier index on ties.
    assign take = (c_cnt == '0) || (logit > max_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val      <= '0;
            max_idx      <= '0;
            argmax_idx   <= '0;
            argmax_valid <= 1'b0;
        end else begin
            argmax_valid <= 1'b0;
            if (hs) begin
                if (take) begin
                    max_val <= logit;
                    max_idx <= c_cnt;
                end
                if (c_last) begin
                    argmax_idx   <= take ? c_cnt : max_idx;
                    argmax_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dense_mac_seq.sv
// Scoreboard bench for dense_mac_seq: ROM model, reference logit model, handshake monitor.
module tb_dense_mac_seq;
    import dense_mac_seq_pkg::*;

    typedef struct {
        int     idx;
        longint data;
        bit     last;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [HID_DIM*N_LEN-1:0] h_in;
    logic [AWIDTH-1:0]        rom_addr;
    logic [LANE_W-1:0]        rom_q;
    logic                     out_valid;
    logic                     out_ready;
    logic [N_LEN-1:0]         out_data;
    logic [IDX_W-1:0]         out_idx;
    logic                     out_last;
`ifdef DENSE_ARGMAX_EN
    logic [IDX_W-1:0]         argmax_idx;
    logic                     argmax_valid;
    int                       am_q[$];
    bit                       am_due = 0;
`endif

    exp_t                     sb[$];
    int                       n_cmp = 0;
    int                       n_err = 0;
    int                       rom_mode = 0;
    logic signed [N_LEN-1:0]  h_cur [HID_DIM];
    bit                       ready_rand = 0;
    bit                       tb_busy = 0;
    bit                       prev_stall = 0;
    logic [N_LEN-1:0]         stall_data;
    logic [IDX_W-1:0]         stall_idx;
    int                       cyc = 0;
    int                       last_hs_cyc = 0;

    dense_mac_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .h_in      (h_in),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef DENSE_ARGMAX_EN
        ,
        .argmax_idx   (argmax_idx),
        .argmax_valid (argmax_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [N_LEN-1:0] wt(input int mode, input int addr, input int lane);
        int c;
        c = addr / W_WORDS;
        case (mode)
            0:       return N_LEN'(256);
            1:       return N_LEN'(((addr*131 + lane*71) % 601) - 300);
            2:       return N_LEN'(c*256);
            3:       return (c % 2 == 0) ? N_LEN'(32767) : N_LEN'(-32768);
            default: return N_LEN'(((c == 20) || (c == 133)) ? 512 : (c % 50));
        endcase
    endfunction

    function automatic longint exp_logit(input int c);
        longint s;
        s = 0;
        for (int k = 0; k < HID_DIM; k++)
            s += longint'(h_cur[k]) * longint'(wt(rom_mode, c*W_WORDS + k/DATA_N, k%DATA_N));
        s = s >>> FRAC;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    // Registered ROM: data for the address seen at an edge appears after that edge.
    always @(posedge clk) begin
        for (int j = 0; j < DATA_N; j++)
            rom_q[j*N_LEN +: N_LEN] <= wt(rom_mode, int'(rom_addr), j);
    end

    task automatic apply_h();
        for (int k = 0; k < HID_DIM; k++)
            h_in[k*N_LEN +: N_LEN] = h_cur[k];
    endtask

    task automatic push_frame();
        longint v, best;
        int best_i;
        best = 0;
        best_i = 0;
        for (int c = 0; c < CHAR_NUM; c++) begin
            v = exp_logit(c);
            sb.push_back('{c, v, (c == CHAR_NUM-1)});
            if (c == 0 || v > best) begin
                best = v;
                best_i = c;
            end
        end
`ifdef DENSE_ARGMAX_EN
        am_q.push_back(best_i);
`else
        if (best_i < 0) $display("unexpected argmax index");
`endif
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_val("idle_timeout", 0, 1);
    endtask

    task automatic send_frame();
        wait_idle();
        @(posedge clk); #1;
        apply_h();
        push_frame();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || tb_busy) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check_val("sb_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic set_h_all(input int v);
        for (int k = 0; k < HID_DIM; k++) h_cur[k] = N_LEN'(v);
    endtask

    task automatic set_h_rand();
        for (int k = 0; k < HID_DIM; k++) h_cur[k] = N_LEN'(int'($urandom_range(0, 4095)) - 2048);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Handshake monitor, sampled on the falling edge.
    initial begin
        exp_t e;
        bit   hs, last_hs;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                hs = out_valid && out_ready;
                last_hs = 1'b0;
                check_val("in_ready", in_ready, !tb_busy);
                if (out_valid && prev_stall) begin
                    check_val("stall_data", out_data, stall_data);
                    check_val("stall_idx", out_idx, stall_idx);
                end
                prev_stall = out_valid && !out_ready;
                stall_data = out_data;
                stall_idx  = out_idx;
`ifdef DENSE_ARGMAX_EN
                if (am_due || argmax_valid) begin
                    check_val("am_valid", argmax_valid, am_due);
                    if (am_due && am_q.size() > 0) check_val("am_idx", argmax_idx, am_q.pop_front());
                end
`endif
                if (hs) begin
                    if (sb.size() == 0) begin
                        check_val("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check_val("idx", out_idx, e.idx);
                        check_val("data", $signed(out_data), e.data);
                        check_val("last", out_last, e.last);
                        if (!ready_rand && e.idx != 0) check_val("tput", cyc - last_hs_cyc, W_WORDS + 2);
                        last_hs = e.last;
                        if (e.last) tb_busy = 1'b0;
                    end
                    last_hs_cyc = cyc;
                end
`ifdef DENSE_ARGMAX_EN
                am_due = last_hs;
`endif
                if (in_valid && in_ready) tb_busy = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        h_in     = '0;
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_idx", out_idx, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_rom_addr", rom_addr, 0);
        #20 rst_n = 1'b1;

        rom_mode = 0; set_h_all(256);
        send_frame(); wait_drain();

        rom_mode = 2; set_h_all(0); h_cur[5] = N_LEN'(128);
        send_frame(); wait_drain();

        rom_mode = 3; set_h_all(32767);
        send_frame(); wait_drain();

        ready_rand = 1; rom_mode = 1; set_h_rand();
        send_frame(); wait_drain();
        ready_rand = 0;

        // A second vector held on in_valid mid-frame must wait for the frame to finish.
        rom_mode = 1; set_h_rand();
        wait_idle();
        @(posedge clk); #1;
        apply_h(); push_frame(); in_valid = 1'b1;
        repeat (100) @(posedge clk);
        #1; set_h_rand(); apply_h(); push_frame();
        wait_idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();

        rom_mode = 0; set_h_all(256);
        send_frame();
        t = 0;
        while (rom_addr != AWIDTH'(57*W_WORDS + 2) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_val("reset_point", rom_addr, 57*W_WORDS + 2);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", out_valid, 0);
        check_val("mid_rst_out_data", out_data, 0);
        check_val("mid_rst_out_idx", out_idx, 0);
        check_val("mid_rst_out_last", out_last, 0);
        check_val("mid_rst_rom_addr", rom_addr, 0);
        check_val("mid_rst_in_ready", in_ready, 1);
        sb.delete();
        tb_busy = 1'b0;
        prev_stall = 1'b0;
`ifdef DENSE_ARGMAX_EN
        am_q.delete();
        am_due = 1'b0;
        check_val("mid_rst_am_valid", argmax_valid, 0);
`endif
        @(negedge clk); #3 rst_n = 1'b1;
        send_frame(); wait_drain();

`ifdef DENSE_ARGMAX_EN
        rom_mode = 4; set_h_all(256);
        send_frame(); wait_drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
